// File: rtl/bus_arb.sv
// Two-master to one-slave bus arbiter.
// Round-robin command arbitration with at most one read outstanding. If the slave
// does not answer a read within TIMEOUT cycles, the arbiter returns an error
// response to the master that issued the read.
module bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // m0: core
    input  logic [31:0] m0_cmd_wdata,
    input  logic [31:0] m0_cmd_addr,
    input  logic        m0_cmd_we,
    input  logic [3:0]  m0_cmd_wem,
    input  logic        m0_cmd_valid,
    output logic        m0_cmd_ready,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_valid,
    input  logic        m0_rsp_ready,
    output logic        m0_rsp_error,
    // m1: debug / DMA
    input  logic [31:0] m1_cmd_wdata,
    input  logic [31:0] m1_cmd_addr,
    input  logic        m1_cmd_we,
    input  logic [3:0]  m1_cmd_wem,
    input  logic        m1_cmd_valid,
    output logic        m1_cmd_ready,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_valid,
    input  logic        m1_rsp_ready,
    output logic        m1_rsp_error,
    // shared slave
    output logic [31:0] s_cmd_wdata,
    output logic [31:0] s_cmd_addr,
    output logic        s_cmd_we,
    output logic [3:0]  s_cmd_wem,
    output logic        s_cmd_valid,
    input  logic        s_cmd_ready,
    input  logic [31:0] s_rsp_rdata,
    input  logic        s_rsp_valid,
    input  logic        s_rsp_error,
    output logic        s_rsp_ready,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StRdWait, StToRsp} state_e;

    localparam logic [9:0] CntLast = 10'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       owner_q, owner_d;
    logic       hold_q, hold_d;
    logic       hold_gnt_q, hold_gnt_d;
    logic [9:0] cnt_q, cnt_d;

    logic gnt;
    logic gnt_valid;
    logic gnt_we;

    // Pick the master presented on the slave bus: a stalled command keeps its grant.
    always_comb begin
        gnt = 1'b0;
        if (hold_q) begin
            gnt = hold_gnt_q;
        end else if (m0_cmd_valid && m1_cmd_valid) begin
            gnt = ~last_gnt_q;
        end else if (m1_cmd_valid) begin
            gnt = 1'b1;
        end
        gnt_valid = gnt ? m1_cmd_valid : m0_cmd_valid;
        gnt_we    = gnt ? m1_cmd_we : m0_cmd_we;
    end

    // Output muxing; reset forces everything quiet except s_rsp_ready.
    always_comb begin
        s_cmd_wdata  = '0;
        s_cmd_addr   = '0;
        s_cmd_we     = 1'b0;
        s_cmd_wem    = '0;
        s_cmd_valid  = 1'b0;
        s_rsp_ready  = 1'b1;
        m0_cmd_ready = 1'b0;
        m1_cmd_ready = 1'b0;
        m0_rsp_rdata = '0;
        m0_rsp_valid = 1'b0;
        m0_rsp_error = 1'b0;
        m1_rsp_rdata = '0;
        m1_rsp_valid = 1'b0;
        m1_rsp_error = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    s_cmd_valid = 1'b1;
                    s_cmd_wdata = gnt ? m1_cmd_wdata : m0_cmd_wdata;
                    s_cmd_addr  = gnt ? m1_cmd_addr : m0_cmd_addr;
                    s_cmd_we    = gnt_we;
                    s_cmd_wem   = gnt ? m1_cmd_wem : m0_cmd_wem;
                    if (gnt) begin
                        m1_cmd_ready = s_cmd_ready;
                    end else begin
                        m0_cmd_ready = s_cmd_ready;
                    end
                end
            end
            StRdWait: begin
                if (owner_q) begin
                    s_rsp_ready  = m1_rsp_ready;
                    m1_rsp_valid = s_rsp_valid;
                    m1_rsp_rdata = s_rsp_rdata;
                    m1_rsp_error = s_rsp_error;
                end else begin
                    s_rsp_ready  = m0_rsp_ready;
                    m0_rsp_valid = s_rsp_valid;
                    m0_rsp_rdata = s_rsp_rdata;
                    m0_rsp_error = s_rsp_error;
                end
            end
            StToRsp: begin
                if (owner_q) begin
                    m1_rsp_valid = 1'b1;
                    m1_rsp_error = 1'b1;
                end else begin
                    m0_rsp_valid = 1'b1;
                    m0_rsp_error = 1'b1;
                end
            end
            default: ;
        endcase
        if (!rst_n) begin
            s_cmd_wdata  = '0;
            s_cmd_addr   = '0;
            s_cmd_we     = 1'b0;
            s_cmd_wem    = '0;
            s_cmd_valid  = 1'b0;
            s_rsp_ready  = 1'b1;
            m0_cmd_ready = 1'b0;
            m1_cmd_ready = 1'b0;
            m0_rsp_rdata = '0;
            m0_rsp_valid = 1'b0;
            m0_rsp_error = 1'b0;
            m1_rsp_rdata = '0;
            m1_rsp_valid = 1'b0;
            m1_rsp_error = 1'b0;
        end
    end

    assign busy_o = (state_q != StIdle);

    // Next-state logic for the FSM, grant history, hold and timeout counter.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        hold_d     = 1'b0;
        hold_gnt_d = hold_gnt_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (s_cmd_valid && !s_cmd_ready) begin
                    hold_d     = 1'b1;
                    hold_gnt_d = gnt;
                end
                if (s_cmd_valid && s_cmd_ready) begin
                    last_gnt_d = gnt;
                    if (!gnt_we) begin
                        owner_d = gnt;
                        cnt_d   = '0;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                if (s_rsp_valid && s_rsp_ready) begin
                    state_d = StIdle;
                end else begin
                    // Saturate so a response stalled by the owner never wraps the count.
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 10'd1;
                    end
                    // A real response, even if not yet accepted, beats the timeout.
                    if (!s_rsp_valid && (cnt_q >= CntLast)) begin
                        state_d = StToRsp;
                    end
                end
            end
            StToRsp: begin
                if (owner_q ? m1_rsp_ready : m0_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; last_gnt resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            hold_q     <= 1'b0;
            hold_gnt_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            hold_q     <= hold_d;
            hold_gnt_q <= hold_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bus_arb.sv
// Directed self-checking bench for bus_arb. Two instances share all inputs:
// dut uses the default TIMEOUT, dut_t uses TIMEOUT=4 for the timeout scenarios.
module tb_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_cmd_wdata, m0_cmd_addr, m1_cmd_wdata, m1_cmd_addr;
    logic        m0_cmd_we, m0_cmd_valid, m0_rsp_ready;
    logic        m1_cmd_we, m1_cmd_valid, m1_rsp_ready;
    logic [3:0]  m0_cmd_wem, m1_cmd_wem;
    logic        s_cmd_ready, s_rsp_valid, s_rsp_error;
    logic [31:0] s_rsp_rdata;

    logic        m0_cmd_ready, m0_rsp_valid, m0_rsp_error;
    logic        m1_cmd_ready, m1_rsp_valid, m1_rsp_error;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata, s_cmd_wdata, s_cmd_addr;
    logic        s_cmd_we, s_cmd_valid, s_rsp_ready, busy_o;
    logic [3:0]  s_cmd_wem;

    logic        m0_cmd_ready_t, m0_rsp_valid_t, m0_rsp_error_t;
    logic        m1_cmd_ready_t, m1_rsp_valid_t, m1_rsp_error_t;
    logic [31:0] m0_rsp_rdata_t, m1_rsp_rdata_t, s_cmd_wdata_t, s_cmd_addr_t;
    logic        s_cmd_we_t, s_cmd_valid_t, s_rsp_ready_t, busy_t;
    logic [3:0]  s_cmd_wem_t;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arb dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_addr(m0_cmd_addr), .m0_cmd_we(m0_cmd_we),
        .m0_cmd_wem(m0_cmd_wem), .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready),
        .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rsp_ready(m0_rsp_ready), .m0_rsp_error(m0_rsp_error),
        .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_addr(m1_cmd_addr), .m1_cmd_we(m1_cmd_we),
        .m1_cmd_wem(m1_cmd_wem), .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready),
        .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rsp_ready(m1_rsp_ready), .m1_rsp_error(m1_rsp_error),
        .s_cmd_wdata(s_cmd_wdata), .s_cmd_addr(s_cmd_addr), .s_cmd_we(s_cmd_we),
        .s_cmd_wem(s_cmd_wem), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_valid(s_rsp_valid), .s_rsp_error(s_rsp_error),
        .s_rsp_ready(s_rsp_ready), .busy_o(busy_o)
    );

    bus_arb #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_addr(m0_cmd_addr), .m0_cmd_we(m0_cmd_we),
        .m0_cmd_wem(m0_cmd_wem), .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready_t),
        .m0_rsp_rdata(m0_rsp_rdata_t), .m0_rsp_valid(m0_rsp_valid_t),
        .m0_rsp_ready(m0_rsp_ready), .m0_rsp_error(m0_rsp_error_t),
        .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_addr(m1_cmd_addr), .m1_cmd_we(m1_cmd_we),
        .m1_cmd_wem(m1_cmd_wem), .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready_t),
        .m1_rsp_rdata(m1_rsp_rdata_t), .m1_rsp_valid(m1_rsp_valid_t),
        .m1_rsp_ready(m1_rsp_ready), .m1_rsp_error(m1_rsp_error_t),
        .s_cmd_wdata(s_cmd_wdata_t), .s_cmd_addr(s_cmd_addr_t), .s_cmd_we(s_cmd_we_t),
        .s_cmd_wem(s_cmd_wem_t), .s_cmd_valid(s_cmd_valid_t), .s_cmd_ready(s_cmd_ready),
        .s_rsp_rdata(s_rsp_rdata), .s_rsp_valid(s_rsp_valid), .s_rsp_error(s_rsp_error),
        .s_rsp_ready(s_rsp_ready_t), .busy_o(busy_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cmd_wdata = '0; m0_cmd_addr = '0; m0_cmd_we = 1'b0; m0_cmd_wem = '0;
        m0_cmd_valid = 1'b0; m0_rsp_ready = 1'b0;
        m1_cmd_wdata = '0; m1_cmd_addr = '0; m1_cmd_we = 1'b0; m1_cmd_wem = '0;
        m1_cmd_valid = 1'b0; m1_rsp_ready = 1'b0;
        s_cmd_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_error = 1'b0; s_rsp_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h44; m1_cmd_valid = 1'b1;
        s_cmd_ready = 1'b1; s_rsp_valid = 1'b1; s_rsp_rdata = 32'hFFFF_0000;
        m0_rsp_ready = 1'b1;
        #1;
        total++;
        if ({s_cmd_valid, m0_cmd_ready, m1_cmd_ready, busy_o, s_rsp_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 00001",
                     {s_cmd_valid, m0_cmd_ready, m1_cmd_ready, busy_o, s_rsp_ready});
        end
        total++;
        if ({s_cmd_addr, s_cmd_wdata, s_cmd_we, s_cmd_wem} !== 69'h0) begin
            bad++;
            $display("FAIL reset_cmd: got %h want 0", {s_cmd_addr, s_cmd_wdata, s_cmd_we, s_cmd_wem});
        end
        total++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_error, m1_rsp_error, m0_rsp_rdata, m1_rsp_rdata}
            !== 68'h0) begin
            bad++;
            $display("FAIL reset_rsp: got v=%b%b d=%h want 0", m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata);
        end
        do_reset();
    endtask

    task automatic test_rr_write();
        do_reset();
        m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m0_cmd_addr = 32'h10; m0_cmd_wdata = 32'h1111;
        m0_cmd_wem = 4'hF;
        m1_cmd_valid = 1'b1; m1_cmd_we = 1'b1; m1_cmd_addr = 32'h20; m1_cmd_wdata = 32'h2222;
        m1_cmd_wem = 4'h3;
        s_cmd_ready = 1'b1;
        #1;
        total++;
        if ({s_cmd_addr, s_cmd_wdata, s_cmd_wem, s_cmd_we} !== {32'h10, 32'h1111, 4'hF, 1'b1}) begin
            bad++;
            $display("FAIL rr_c1_cmd: got %h/%h want 10/1111", s_cmd_addr, s_cmd_wdata);
        end
        total++;
        if ({m0_cmd_ready, m1_cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rr_c1_ready: got %b want 10", {m0_cmd_ready, m1_cmd_ready});
        end
        tick();
        m0_cmd_addr = 32'h14; m0_cmd_wdata = 32'h3333;
        #1;
        total++;
        if ({s_cmd_addr, s_cmd_wem, m0_cmd_ready, m1_cmd_ready} !== {32'h20, 4'h3, 2'b01}) begin
            bad++;
            $display("FAIL rr_c2: got addr=%h rdy=%b want 20/01", s_cmd_addr, {m0_cmd_ready, m1_cmd_ready});
        end
        tick();
        #1;
        total++;
        if ({s_cmd_addr, m0_cmd_ready, m1_cmd_ready, busy_o} !== {32'h14, 3'b100}) begin
            bad++;
            $display("FAIL rr_c3_tie: got addr=%h rdy=%b want 14/10", s_cmd_addr, {m0_cmd_ready, m1_cmd_ready});
        end
        tick();
        m0_cmd_valid = 1'b0; m1_cmd_valid = 1'b0;
        #1;
        total++;
        if ({s_cmd_valid, s_cmd_addr, s_cmd_wdata, s_cmd_we, s_cmd_wem} !== 70'h0) begin
            bad++;
            $display("FAIL idle_zero: got %h want 0", {s_cmd_valid, s_cmd_addr, s_cmd_wdata});
        end
    endtask

    task automatic test_hold();
        do_reset();
        m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m0_cmd_addr = 32'h30; s_cmd_ready = 1'b1;
        tick();
        // last grant is now m0, so a plain tie would go to m1
        m0_cmd_we = 1'b0; m0_cmd_addr = 32'h1000; s_cmd_ready = 1'b0;
        #1;
        total++;
        if ({s_cmd_addr, s_cmd_valid, m0_cmd_ready} !== {32'h1000, 2'b10}) begin
            bad++;
            $display("FAIL hold_c1: got addr=%h v=%b want 1000/1", s_cmd_addr, s_cmd_valid);
        end
        tick();
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h2000;
        for (int i = 0; i < 3; i++) begin
            s_cmd_ready = (i == 2);
            #1;
            total++;
            if ({s_cmd_addr, m0_cmd_ready, m1_cmd_ready} !== {32'h1000, (i == 2), 1'b0}) begin
                bad++;
                $display("FAIL hold_c%0d: got addr=%h rdy=%b want 1000/%b0", i + 2, s_cmd_addr,
                         {m0_cmd_ready, m1_cmd_ready}, (i == 2));
            end
            tick();
        end
        m0_cmd_valid = 1'b0; m0_rsp_ready = 1'b0;
        #1;
        total++;
        if ({s_cmd_valid, m1_cmd_ready, busy_o, s_rsp_ready} !== 4'b0010) begin
            bad++;
            $display("FAIL rdwait_ctrl: got %b want 0010", {s_cmd_valid, m1_cmd_ready, busy_o, s_rsp_ready});
        end
        tick();
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h1234_5678; s_rsp_error = 1'b1; m0_rsp_ready = 1'b1;
        #1;
        total++;
        if ({m0_rsp_valid, m0_rsp_error, m0_rsp_rdata, m1_rsp_valid, m1_cmd_ready, s_rsp_ready}
            !== {2'b11, 32'h1234_5678, 3'b001}) begin
            bad++;
            $display("FAIL hold_rsp: got v=%b e=%b d=%h m1v=%b want 1/1/12345678/0",
                     m0_rsp_valid, m0_rsp_error, m0_rsp_rdata, m1_rsp_valid);
        end
        tick();
        s_rsp_valid = 1'b0; s_rsp_error = 1'b0;
        #1;
        total++;
        if ({s_cmd_addr, m1_cmd_ready, busy_o} !== {32'h2000, 2'b10}) begin
            bad++;
            $display("FAIL hold_m1_gnt: got addr=%h rdy=%b busy=%b want 2000/1/0", s_cmd_addr,
                     m1_cmd_ready, busy_o);
        end
    endtask

    task automatic test_read_rsp();
        do_reset();
        m1_cmd_valid = 1'b1; m1_cmd_addr = 32'h2000; s_cmd_ready = 1'b1;
        tick();
        m1_cmd_valid = 1'b0; m1_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({m1_rsp_valid, busy_o} !== 2'b01) begin
                bad++;
                $display("FAIL rd_wait%0d: got v=%b busy=%b want 0/1", i, m1_rsp_valid, busy_o);
            end
            tick();
        end
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({m1_rsp_valid, m1_rsp_rdata, m1_rsp_error} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL rd_m1_rsp: got v=%b d=%h want 1/deadbeef", m1_rsp_valid, m1_rsp_rdata);
        end
        total++;
        if ({m0_rsp_valid, m0_rsp_rdata} !== 33'h0) begin
            bad++;
            $display("FAIL rd_m0_quiet: got v=%b d=%h want 0/0", m0_rsp_valid, m0_rsp_rdata);
        end
        tick();
        s_rsp_valid = 1'b0;
        #1;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rd_busy_drop: got %b want 0", busy_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h3000; s_cmd_ready = 1'b1;
        tick();
        m0_cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({m0_rsp_valid_t, busy_t} !== 2'b01) begin
                bad++;
                $display("FAIL to_wait%0d: got v=%b busy=%b want 0/1", i, m0_rsp_valid_t, busy_t);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({m0_rsp_valid_t, m0_rsp_error_t, m0_rsp_rdata_t, m1_rsp_valid_t, s_rsp_ready_t}
                !== {2'b11, 32'h0, 2'b01}) begin
                bad++;
                $display("FAIL to_rsp%0d: got v=%b e=%b d=%h m1v=%b srdy=%b want 1/1/0/0/1", i,
                         m0_rsp_valid_t, m0_rsp_error_t, m0_rsp_rdata_t, m1_rsp_valid_t, s_rsp_ready_t);
            end
            if (i == 1) m0_rsp_ready = 1'b1;
            tick();
        end
        m0_rsp_ready = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h55;
        m1_cmd_valid = 1'b1; m1_cmd_we = 1'b1; m1_cmd_addr = 32'h40;
        #1;
        total++;
        if ({busy_t, m0_rsp_valid_t, m1_rsp_valid_t, s_rsp_ready_t, m1_cmd_ready_t} !== 5'b00011) begin
            bad++;
            $display("FAIL late_rsp: got %b want 00011",
                     {busy_t, m0_rsp_valid_t, m1_rsp_valid_t, s_rsp_ready_t, m1_cmd_ready_t});
        end
        tick();
    endtask

    task automatic test_race();
        do_reset();
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h3004; s_cmd_ready = 1'b1;
        tick();
        m0_cmd_valid = 1'b0;
        repeat (3) tick();
        // counter is at TIMEOUT-1 here; the real response must take precedence
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({m0_rsp_valid_t, m0_rsp_error_t, m0_rsp_rdata_t} !== {2'b10, 32'hA5A5_A5A5}) begin
                bad++;
                $display("FAIL race%0d: got v=%b e=%b d=%h want 1/0/a5a5a5a5", i, m0_rsp_valid_t,
                         m0_rsp_error_t, m0_rsp_rdata_t);
            end
            if (i == 1) m0_rsp_ready = 1'b1;
            tick();
        end
        s_rsp_valid = 1'b0; m0_rsp_ready = 1'b0;
        #1;
        total++;
        if (busy_t !== 1'b0) begin
            bad++;
            $display("FAIL race_idle: got busy=%b want 0", busy_t);
        end
    endtask

    task automatic test_reset_midread();
        do_reset();
        m0_cmd_valid = 1'b1; m0_cmd_addr = 32'h4000; s_cmd_ready = 1'b1;
        tick();
        m0_cmd_valid = 1'b0;
        s_rsp_valid = 1'b1; s_rsp_rdata = 32'h77;
        #1;
        total++;
        if ({busy_o, m0_rsp_valid} !== 2'b11) begin
            bad++;
            $display("FAIL mid_pre: got busy=%b v=%b want 1/1", busy_o, m0_rsp_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy_o, busy_t, m0_rsp_valid, s_rsp_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL mid_async: got %b want 0001", {busy_o, busy_t, m0_rsp_valid, s_rsp_ready});
        end
        tick();
        rst_n = 1'b1;
        m0_rsp_ready = 1'b1;
        m0_cmd_valid = 1'b1; m0_cmd_we = 1'b1; m1_cmd_valid = 1'b1; m1_cmd_we = 1'b1;
        #1;
        total++;
        if ({m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 5'b10001) begin
            bad++;
            $display("FAIL mid_after: got %b want 10001",
                     {m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_rr_write();
        test_hold();
        test_read_rsp();
        test_timeout();
        test_race();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
